// File: rtl/glb_tile_cfg_router.sv
// glb_tile_cfg_router: configuration-bus router for one global-buffer tile.
// Requests addressed to this tile are driven onto the local register bus
// (pio_*). All other requests are registered and forwarded east. Read
// responses from the local bus and from the east share one response FIFO.
// The FIFO drains one entry per cycle toward the west.
// Optional build macro: GLB_CFG_RD_TIMEOUT_EN. When it is defined, a tracked
// local read that gets neither ack nor nack returns all-ones data. When it is
// not defined, such a read produces no response.
module glb_tile_cfg_router #(
    parameter int REG_ADDR_WIDTH = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int TILE_ID_WIDTH  = 5,
    parameter int RD_LATENCY     = 2,
    parameter int RSP_DEPTH      = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [TILE_ID_WIDTH-1:0]                glb_tile_id,
    input  logic                                    w_wr_en,
    input  logic [TILE_ID_WIDTH+REG_ADDR_WIDTH+1:0] w_wr_addr,
    input  logic [DATA_WIDTH-1:0]                   w_wr_data,
    input  logic                                    w_rd_en,
    input  logic [TILE_ID_WIDTH+REG_ADDR_WIDTH+1:0] w_rd_addr,
    output logic [DATA_WIDTH-1:0]                   w_rd_data,
    output logic                                    w_rd_data_valid,
    output logic                                    e_wr_en,
    output logic [TILE_ID_WIDTH+REG_ADDR_WIDTH+1:0] e_wr_addr,
    output logic [DATA_WIDTH-1:0]                   e_wr_data,
    output logic                                    e_rd_en,
    output logic [TILE_ID_WIDTH+REG_ADDR_WIDTH+1:0] e_rd_addr,
    input  logic [DATA_WIDTH-1:0]                   e_rd_data,
    input  logic                                    e_rd_data_valid,
    output logic                                    pio_write,
    output logic                                    pio_read,
    output logic [REG_ADDR_WIDTH-1:0]               pio_addr,
    output logic [DATA_WIDTH-1:0]                   pio_wr_data,
    input  logic [DATA_WIDTH-1:0]                   pio_rd_data,
    input  logic                                    pio_ack,
    input  logic                                    pio_nack,
    output logic                                    rsp_overflow
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TILE_LSB = REG_ADDR_WIDTH + 2;

    logic wr_local, wr_fwd, rd_local, rd_fwd;

    assign wr_local = w_wr_en && (w_wr_addr[TILE_LSB +: TILE_ID_WIDTH] == glb_tile_id);
    assign rd_local = w_rd_en && (w_rd_addr[TILE_LSB +: TILE_ID_WIDTH] == glb_tile_id);
    assign wr_fwd   = w_wr_en && !wr_local;
    assign rd_fwd   = w_rd_en && !rd_local;

    // Local register bus request. The write address wins when a read and a write arrive together.
    always_comb begin
        pio_write   = wr_local;
        pio_read    = rd_local;
        pio_addr    = '0;
        pio_wr_data = '0;
        if (wr_local) begin
            pio_addr    = w_wr_addr[2 +: REG_ADDR_WIDTH];
            pio_wr_data = w_wr_data;
        end else if (rd_local) begin
            pio_addr = w_rd_addr[2 +: REG_ADDR_WIDTH];
        end
    end

    // Forward non-local requests east one cycle later. Idle fields are zeroed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_wr_en   <= 1'b0;
            e_wr_addr <= '0;
            e_wr_data <= '0;
            e_rd_en   <= 1'b0;
            e_rd_addr <= '0;
        end else begin
            e_wr_en   <= wr_fwd;
            e_wr_addr <= wr_fwd ? w_wr_addr : '0;
            e_wr_data <= wr_fwd ? w_wr_data : '0;
            e_rd_en   <= rd_fwd;
            e_rd_addr <= rd_fwd ? w_rd_addr : '0;
        end
    end

    logic [RD_LATENCY-1:0] rd_pipe;

    // Track in-flight local reads. The last stage marks the cycle in which the response is sampled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= rd_local;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    logic                  rd_due;
    logic                  loc_push;
    logic [DATA_WIDTH-1:0] loc_data;

    assign rd_due = rd_pipe[RD_LATENCY-1];

`ifdef GLB_CFG_RD_TIMEOUT_EN
    assign loc_push = rd_due;
    assign loc_data = (pio_ack || pio_nack) ? pio_rd_data : '1;
`else
    assign loc_push = rd_due && (pio_ack || pio_nack);
    assign loc_data = pio_rd_data;
`endif

    logic [DATA_WIDTH-1:0] rsp_mem [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  pop;
    logic [CNT_W-1:0]      free_slots;
    logic [CNT_W-1:0]      free_after_loc;
    logic                  acc_loc, acc_e, drop;
    logic [CNT_W-1:0]      n_push;
    logic [PTR_W-1:0]      e_slot;

    // Push arbitration. The local response claims space first, and a same-cycle pop frees one slot.
    always_comb begin
        pop            = (count != '0);
        free_slots     = CNT_W'(RSP_DEPTH) - count + CNT_W'(pop);
        acc_loc        = loc_push && (free_slots != '0);
        free_after_loc = free_slots - CNT_W'(acc_loc);
        acc_e          = e_rd_data_valid && (free_after_loc != '0);
        drop           = (loc_push && !acc_loc) || (e_rd_data_valid && !acc_e);
        n_push         = CNT_W'(acc_loc) + CNT_W'(acc_e);
        e_slot         = acc_loc ? wr_ptr + PTR_W'(1) : wr_ptr;
    end

    // FIFO storage. It needs no reset because occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (acc_loc) rsp_mem[wr_ptr] <= loc_data;
        if (acc_e)   rsp_mem[e_slot] <= e_rd_data;
    end

    // FIFO pointers, occupancy, west response register and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            w_rd_data       <= '0;
            w_rd_data_valid <= 1'b0;
            rsp_overflow    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + n_push[PTR_W-1:0];
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + n_push - CNT_W'(pop);
            if (pop) begin
                w_rd_data       <= rsp_mem[rd_ptr];
                w_rd_data_valid <= 1'b1;
            end else begin
                w_rd_data       <= '0;
                w_rd_data_valid <= 1'b0;
            end
            if (drop) rsp_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_glb_tile_cfg_router.sv
// Directed bench for glb_tile_cfg_router. It runs with tile ID 3,
// RD_LATENCY=2 and RSP_DEPTH=2.
module tb_glb_tile_cfg_router;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  glb_tile_id = 5'd3;
    logic        w_wr_en = 1'b0;
    logic [12:0] w_wr_addr = '0;
    logic [31:0] w_wr_data = '0;
    logic        w_rd_en = 1'b0;
    logic [12:0] w_rd_addr = '0;
    logic [31:0] w_rd_data;
    logic        w_rd_data_valid;
    logic        e_wr_en;
    logic [12:0] e_wr_addr;
    logic [31:0] e_wr_data;
    logic        e_rd_en;
    logic [12:0] e_rd_addr;
    logic [31:0] e_rd_data = '0;
    logic        e_rd_data_valid = 1'b0;
    logic        pio_write, pio_read;
    logic [5:0]  pio_addr;
    logic [31:0] pio_wr_data;
    logic [31:0] pio_rd_data = '0;
    logic        pio_ack = 1'b0;
    logic        pio_nack = 1'b0;
    logic        rsp_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    glb_tile_cfg_router #(
        .REG_ADDR_WIDTH(6), .DATA_WIDTH(32), .TILE_ID_WIDTH(5),
        .RD_LATENCY(2), .RSP_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset), .glb_tile_id(glb_tile_id),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .w_rd_data(w_rd_data), .w_rd_data_valid(w_rd_data_valid),
        .e_wr_en(e_wr_en), .e_wr_addr(e_wr_addr), .e_wr_data(e_wr_data),
        .e_rd_en(e_rd_en), .e_rd_addr(e_rd_addr),
        .e_rd_data(e_rd_data), .e_rd_data_valid(e_rd_data_valid),
        .pio_write(pio_write), .pio_read(pio_read), .pio_addr(pio_addr),
        .pio_wr_data(pio_wr_data), .pio_rd_data(pio_rd_data),
        .pio_ack(pio_ack), .pio_nack(pio_nack), .rsp_overflow(rsp_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] mk(input logic [4:0] tile, input logic [5:0] off);
        return {tile, off, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Single-cycle request vectors: pio = {write, read, addr, wr_data}; east = {wr_en, wr_addr, wr_data, rd_en, rd_addr}
    typedef struct {
        logic        wr_en;
        logic [12:0] wr_addr;
        logic [31:0] wr_data;
        logic        rd_en;
        logic [12:0] rd_addr;
        logic [39:0] exp_pio;
        logic [59:0] exp_e;
    } vec_t;

    vec_t vecs [9];

    // Multi-cycle sequence rows, driven one row per clock cycle
    typedef struct {
        logic        rst;
        logic        rd_en;
        logic [5:0]  off;
        logic        ack;
        logic        nack;
        logic [31:0] pdata;
        logic        ev;
        logic [31:0] edata;
        logic        exp_v;
        logic [31:0] exp_d;
    } cyc_t;

    cyc_t seq [16];

    task automatic clear_seq();
        for (int k = 0; k < 16; k++) begin
            seq[k] = '{rst: 1'b0, rd_en: 1'b0, off: 6'd0, ack: 1'b0, nack: 1'b0,
                       pdata: 32'h0, ev: 1'b0, edata: 32'h0, exp_v: 1'b0, exp_d: 32'h0};
        end
    endtask

    task automatic idle_inputs();
        w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
        w_rd_en = 1'b0; w_rd_addr = '0;
        pio_ack = 1'b0; pio_nack = 1'b0; pio_rd_data = '0;
        e_rd_data_valid = 1'b0; e_rd_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_seq(input string name);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            reset           = seq[k].rst;
            w_rd_en         = seq[k].rd_en;
            w_rd_addr       = seq[k].rd_en ? mk(5'd3, seq[k].off) : 13'h0;
            pio_ack         = seq[k].ack;
            pio_nack        = seq[k].nack;
            pio_rd_data     = seq[k].pdata;
            e_rd_data_valid = seq[k].ev;
            e_rd_data       = seq[k].edata;
            #1;
            if (seq[k].rd_en)
                chk($sformatf("%s_pio[%0d]", name, k), {57'h0, pio_read, pio_addr},
                    {57'h0, 1'b1, seq[k].off});
            chk($sformatf("%s_rsp[%0d]", name, k), {31'h0, w_rd_data_valid, w_rd_data},
                {31'h0, seq[k].exp_v, seq[k].exp_d});
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        vecs[0] = '{1'b1, mk(3, 9),  32'hDEAD0001, 1'b0, 13'h0,
                    {1'b1, 1'b0, 6'd9, 32'hDEAD0001}, 60'h0};
        vecs[1] = '{1'b0, 13'h0, 32'h0, 1'b1, mk(3, 5),
                    {1'b0, 1'b1, 6'd5, 32'h0}, 60'h0};
        vecs[2] = '{1'b1, mk(3, 10), 32'h0BAD0002, 1'b1, mk(3, 20),
                    {1'b1, 1'b1, 6'd10, 32'h0BAD0002}, 60'h0};
        vecs[3] = '{1'b1, mk(7, 1),  32'h12345678, 1'b0, 13'h0,
                    40'h0, {1'b1, mk(7, 1), 32'h12345678, 1'b0, 13'h0}};
        vecs[4] = '{1'b0, 13'h0, 32'h0, 1'b1, mk(0, 63),
                    40'h0, {1'b0, 13'h0, 32'h0, 1'b1, mk(0, 63)}};
        vecs[5] = '{1'b1, mk(3, 2),  32'h00C0FFEE, 1'b1, mk(31, 0),
                    {1'b1, 1'b0, 6'd2, 32'h00C0FFEE}, {1'b0, 13'h0, 32'h0, 1'b1, mk(31, 0)}};
        vecs[6] = '{1'b0, 13'h0, 32'h0, 1'b0, 13'h0, 40'h0, 60'h0};
        vecs[7] = '{1'b1, mk(4, 3),  32'hFACE0003, 1'b1, mk(3, 63),
                    {1'b0, 1'b1, 6'd63, 32'h0}, {1'b1, mk(4, 3), 32'hFACE0003, 1'b0, 13'h0}};
        vecs[8] = '{1'b0, mk(3, 4),  32'h11111111, 1'b0, mk(3, 4), 40'h0, 60'h0};

        // Reset state
        @(negedge clk);
        #1;
        chk("reset_outputs", {rsp_overflow, w_rd_data_valid, w_rd_data, e_wr_en, e_rd_en},
            64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Routing vectors
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            w_wr_en = vecs[i].wr_en; w_wr_addr = vecs[i].wr_addr; w_wr_data = vecs[i].wr_data;
            w_rd_en = vecs[i].rd_en; w_rd_addr = vecs[i].rd_addr;
            #1;
            chk($sformatf("vec%0d_pio", i), {24'h0, pio_write, pio_read, pio_addr, pio_wr_data},
                {24'h0, vecs[i].exp_pio});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_east", i),
                {4'h0, e_wr_en, e_wr_addr, e_wr_data, e_rd_en, e_rd_addr},
                {4'h0, vecs[i].exp_e});
        end

        // Local read acked with A5A5A5A5 returns 4 cycles later; a stray ack is ignored
        do_reset();
        clear_seq();
        seq[0].rd_en = 1'b1; seq[0].off = 6'd5;
        seq[2].ack = 1'b1; seq[2].pdata = 32'hA5A5A5A5;
        seq[4].exp_v = 1'b1; seq[4].exp_d = 32'hA5A5A5A5;
        seq[6].ack = 1'b1; seq[6].pdata = 32'h00000077;
        run_seq("local_read");

        // Local + east same cycle, then a nacked read and a lone east response
        do_reset();
        clear_seq();
        seq[0].rd_en = 1'b1; seq[0].off = 6'd7;
        seq[2].ack = 1'b1; seq[2].pdata = 32'hCAFE0001; seq[2].ev = 1'b1; seq[2].edata = 32'h00001234;
        seq[4].exp_v = 1'b1; seq[4].exp_d = 32'hCAFE0001;
        seq[5].exp_v = 1'b1; seq[5].exp_d = 32'h00001234;
        seq[3].rd_en = 1'b1; seq[3].off = 6'd8;
        seq[5].nack = 1'b1; seq[5].pdata = 32'hBEEF0002;
        seq[7].exp_v = 1'b1; seq[7].exp_d = 32'hBEEF0002;
        seq[8].ev = 1'b1; seq[8].edata = 32'h00005555;
        seq[10].exp_v = 1'b1; seq[10].exp_d = 32'h00005555;
        run_seq("dual_push");
        chk("no_overflow", {63'h0, rsp_overflow}, 64'h0);

        // Sustained dual pushes into a 2-entry FIFO: east entries after the first are dropped
        do_reset();
        clear_seq();
        for (int i = 0; i < 4; i++) begin
            seq[i].rd_en = 1'b1; seq[i].off = 6'(i + 1);
            seq[i+2].ack = 1'b1; seq[i+2].pdata = 32'h1000 + i;
            seq[i+2].ev = 1'b1; seq[i+2].edata = 32'h2000 + i;
        end
        seq[4] = '{seq[4].rst, seq[4].rd_en, seq[4].off, seq[4].ack, seq[4].nack,
                   seq[4].pdata, seq[4].ev, seq[4].edata, 1'b1, 32'h1000};
        seq[5].exp_v = 1'b1; seq[5].exp_d = 32'h2000;
        seq[6].exp_v = 1'b1; seq[6].exp_d = 32'h1001;
        seq[7].exp_v = 1'b1; seq[7].exp_d = 32'h1002;
        seq[8].exp_v = 1'b1; seq[8].exp_d = 32'h1003;
        run_seq("overflow");
        chk("overflow_set", {63'h0, rsp_overflow}, 64'h1);
        repeat (5) @(negedge clk);
        chk("overflow_sticky", {63'h0, rsp_overflow}, 64'h1);
        do_reset();
        #1;
        chk("overflow_cleared", {63'h0, rsp_overflow}, 64'h0);

        // Local read that gets no ack or nack
        do_reset();
        clear_seq();
        seq[0].rd_en = 1'b1; seq[0].off = 6'd9;
`ifdef GLB_CFG_RD_TIMEOUT_EN
        seq[4].exp_v = 1'b1; seq[4].exp_d = 32'hFFFFFFFF;
`endif
        run_seq("no_ack");

        // Reset during an in-flight read discards it
        do_reset();
        clear_seq();
        seq[0].rd_en = 1'b1; seq[0].off = 6'd11;
        seq[1].rst = 1'b1;
        seq[2].ack = 1'b1; seq[2].pdata = 32'h5A5A5A5A;
        run_seq("reset_mid_read");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
